// File: rtl/serial_pair_serializer.sv
// -----------------------------------------------------------------------------
// serial_pair_serializer
//
// Transmit end for the serial comparators. Accepts two W-bit operands as one
// word and emits them one bit per beat on the serial pair (out_a, out_b).
// The bit order is chosen per word (MSB-first or LSB-first). Valid/ready
// handshakes on both sides allow back-to-back words without a bubble.
//
// Optional feature: define SERIAL_PAIR_SERIALIZER_PARITY_EN to append one
// parity beat per word (out_a = ^A, out_b = ^B), giving W+1 beats per word.
//
// Parameters:
//   W             operand width in bits (W >= 2), beats per word
//
// Ports:
//   clk           clock, all logic on posedge
//   rst           synchronous active-high reset
//   in_valid      producer offers in_a/in_b/in_msb_first
//   in_ready      serializer can accept a word this cycle
//   in_a, in_b    operands A and B (W bits)
//   in_msb_first  1: emit bit W-1 first, 0: emit bit 0 first
//   out_valid     current beat is valid
//   out_ready     consumer takes the current beat
//   out_a, out_b  current bit of A and B
//   out_first     current beat is beat 0 of the word
//   out_last      current beat is the final beat of the word
// -----------------------------------------------------------------------------
module serial_pair_serializer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_msb_first,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_a,
    output logic         out_b,
    output logic         out_first,
    output logic         out_last
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam int CW = $clog2(W + 1);
`ifdef SERIAL_PAIR_SERIALIZER_PARITY_EN
    localparam int LAST_IDX = W;
`else
    localparam int LAST_IDX = W - 1;
`endif
    localparam logic [CW-1:0] LAST_BEAT = CW'(LAST_IDX);

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   sh_a;
    logic [W-1:0]   sh_b;
    logic           msb_first_q;
    logic [CW-1:0]  beat_cnt;
    logic           accept;
    logic           advance;
    logic           at_last;
    logic           bit_a;
    logic           bit_b;
`ifdef SERIAL_PAIR_SERIALIZER_PARITY_EN
    logic           par_a;
    logic           par_b;
`endif

    // Handshake decode and next-state logic. in_ready opens on the last
    // beat's handshake so the next word loads on the same edge the current
    // word finishes, which is what removes the bubble between words.
    always_comb begin
        at_last    = (beat_cnt == LAST_BEAT);
        out_valid  = (state == SHIFT);
        out_first  = out_valid & (beat_cnt == '0);
        out_last   = out_valid & at_last;
        advance    = out_valid & out_ready;
        in_ready   = (state == IDLE) | (advance & at_last);
        accept     = in_valid & in_ready;
        state_next = state;
        if (accept) begin
            state_next = SHIFT;
        end else if (advance && at_last) begin
            state_next = IDLE;
        end
    end

    // Serial data selection. The current bit always sits at one end of the
    // shift register, chosen by the order latched with the word. Outputs are
    // forced to zero outside SHIFT.
    always_comb begin
        bit_a = msb_first_q ? sh_a[W-1] : sh_a[0];
        bit_b = msb_first_q ? sh_b[W-1] : sh_b[0];
`ifdef SERIAL_PAIR_SERIALIZER_PARITY_EN
        if (at_last) begin
            bit_a = par_a;
            bit_b = par_b;
        end
`endif
        out_a = out_valid & bit_a;
        out_b = out_valid & bit_b;
    end

    // State, beat counter and shift registers. The counter returns to zero
    // when a word completes so it never passes the last beat index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            sh_a        <= '0;
            sh_b        <= '0;
            msb_first_q <= 1'b0;
`ifdef SERIAL_PAIR_SERIALIZER_PARITY_EN
            par_a       <= 1'b0;
            par_b       <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                sh_a        <= in_a;
                sh_b        <= in_b;
                msb_first_q <= in_msb_first;
                beat_cnt    <= '0;
`ifdef SERIAL_PAIR_SERIALIZER_PARITY_EN
                par_a       <= ^in_a;
                par_b       <= ^in_b;
`endif
            end else if (advance) begin
                if (at_last) begin
                    beat_cnt <= '0;
                end else begin
                    beat_cnt <= beat_cnt + CW'(1);
                end
                if (msb_first_q) begin
                    sh_a <= sh_a << 1;
                    sh_b <= sh_b << 1;
                end else begin
                    sh_a <= sh_a >> 1;
                    sh_b <= sh_b >> 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_pair_serializer.sv
// -----------------------------------------------------------------------------
// tb_serial_pair_serializer
//
// Directed bench for serial_pair_serializer (W=16). A table of words with
// hand-computed serial streams is pushed through the serializer; hand-written
// sequences cover back-to-back words, out_ready stalls and mid-word reset.
// Streams are written as 16-bit words whose bit 15 is beat 0.
// Honours SERIAL_PAIR_SERIALIZER_PARITY_EN (adds the parity beat).
// -----------------------------------------------------------------------------
module tb_serial_pair_serializer;

    localparam int W = 16;
`ifdef SERIAL_PAIR_SERIALIZER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_msb_first;
    logic         out_valid;
    logic         out_ready;
    logic         out_a;
    logic         out_b;
    logic         out_first;
    logic         out_last;

    int total;
    int bad;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         msb;
        logic [W-1:0] sa;
        logic [W-1:0] sb;
        logic         pa;
        logic         pb;
    } vec_t;

    vec_t vecs[4];

    serial_pair_serializer #(.W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_msb_first (in_msb_first),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_a        (out_a),
        .out_b        (out_b),
        .out_first    (out_first),
        .out_last     (out_last)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare {out_valid, out_a, out_b, out_first, out_last, in_ready}
    task automatic checkOutput(input string name, input logic [5:0] exp);
        logic [5:0] got;
        got = {out_valid, out_a, out_b, out_first, out_last, in_ready};
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%b exp=%b (valid,a,b,first,last,in_ready)",
                     name, got, exp);
        end
    endtask

    // Offer one word while idle and drop in_valid after the accepting edge;
    // operand inputs are then scrambled to show they are ignored mid-word.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic msb, input string name);
        @(negedge clk);
        in_a         = a;
        in_b         = b;
        in_msb_first = msb;
        in_valid     = 1'b1;
        out_ready    = 1'b1;
        #1;
        checkOutput({name, " idle"}, 6'b000001);
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        in_a         = ~a;
        in_b         = ~b;
        in_msb_first = ~msb;
    endtask

    // Walk the beats of one accepted word, optionally stalling out_ready
    // at random; each sampled cycle must show the expected beat.
    task automatic checkWord(input logic [W-1:0] sa, input logic [W-1:0] sb,
                             input logic pa, input logic pb, input logic stall,
                             input string name);
        int k;
        int cycles;
        logic ea, eb, ef, el;
        k = 0;
        cycles = 0;
        while (k < NB && cycles < 200) begin
            @(negedge clk);
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (k < W) begin
                ea = sa[W-1-k];
                eb = sb[W-1-k];
            end else begin
                ea = pa;
                eb = pb;
            end
            ef = (k == 0);
            el = (k == NB - 1);
            checkOutput($sformatf("%s beat%0d", name, k),
                        {1'b1, ea, eb, ef, el, out_ready & el});
            if (out_ready) k++;
            cycles++;
        end
        if (k < NB) begin
            total++;
            bad++;
            $display("[TB] FAIL %s timeout got_beats=%0d exp_beats=%0d", name, k, NB);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_a         = '0;
        in_b         = '0;
        in_msb_first = 1'b0;
        out_ready    = 1'b1;

        vecs[0] = '{a:16'h6482, b:16'h6262, msb:1'b1, sa:16'h6482, sb:16'h6262, pa:1'b1, pb:1'b0};
        vecs[1] = '{a:16'h6482, b:16'h6262, msb:1'b0, sa:16'h4126, sb:16'h4646, pa:1'b1, pb:1'b0};
        vecs[2] = '{a:16'h0001, b:16'hF000, msb:1'b0, sa:16'h8000, sb:16'h000F, pa:1'b1, pb:1'b0};
        vecs[3] = '{a:16'h8001, b:16'h7FFE, msb:1'b1, sa:16'h8001, sb:16'h7FFE, pa:1'b0, pb:1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset held", 6'b000001);
        rst = 1'b0;
        #1;
        checkOutput("reset released", 6'b000001);

        // Table-driven words, full-rate consumer
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].msb, $sformatf("vec%0d", i));
            checkWord(vecs[i].sa, vecs[i].sb, vecs[i].pa, vecs[i].pb, 1'b0,
                      $sformatf("vec%0d", i));
            @(negedge clk);
            #1;
            checkOutput($sformatf("vec%0d back to idle", i), 6'b000001);
        end

        // Back-to-back: second word held valid through the first
        $display("[TB] back-to-back words");
        applyStimulus(16'h6482, 16'h6262, 1'b1, "b2b w0");
        in_a         = 16'hFFFF;
        in_b         = 16'h0000;
        in_msb_first = 1'b1;
        in_valid     = 1'b1;
        checkWord(16'h6482, 16'h6262, 1'b1, 1'b0, 1'b0, "b2b w0");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = 16'h1234;
        checkWord(16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, "b2b w1");
        @(negedge clk);
        #1;
        checkOutput("b2b idle", 6'b000001);

        // Random out_ready stalls
        $display("[TB] out_ready stalls");
        applyStimulus(16'h6482, 16'h6262, 1'b1, "stall");
        checkWord(16'h6482, 16'h6262, 1'b1, 1'b0, 1'b1, "stall");
        @(negedge clk);
        #1;
        checkOutput("stall idle", 6'b000001);

        // Reset at beat 7 aborts the word
        $display("[TB] mid-word reset");
        applyStimulus(16'h6482, 16'h6262, 1'b1, "rstmid");
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("rstmid beat%0d", k),
                        {1'b1, vecs[0].sa[W-1-k], vecs[0].sb[W-1-k], k == 0, 1'b0, 1'b0});
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rstmid after reset", 6'b000001);
        @(negedge clk);
        #1;
        checkOutput("rstmid no stray beats", 6'b000001);
        applyStimulus(vecs[1].a, vecs[1].b, vecs[1].msb, "rstmid next");
        checkWord(vecs[1].sa, vecs[1].sb, vecs[1].pa, vecs[1].pb, 1'b0, "rstmid next");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=running exp=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
